// File: rtl/alu_reg_file_pkg.sv
// rtl/alu_reg_file_pkg.sv - shared widths, loader state encoding and zero-register address
package alu_reg_file_pkg;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      L0 = 2'd0,
      L1 = 2'd1,
      L2 = 2'd2,
      L3 = 2'd3
   } loader_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/alu_reg_file_if.sv
// rtl/alu_reg_file_if.sv - register-file bus: operand reads, write-back, byte loader, flags
interface alu_reg_file_if;
   import alu_reg_file_pkg::*;

   logic [ADDR_W-1:0] R_Addr_A;
   logic [ADDR_W-1:0] R_Addr_B;
   logic [ADDR_W-1:0] W_Addr;
   logic              Write_Reg;
   logic [DATA_W-1:0] ALU_F;
   logic              ALU_ZF;
   logic              ALU_OF;
   logic              Flag_Load;
   logic [7:0]        SW_Byte;
   logic              Byte_Load;
   logic [DATA_W-1:0] R_Data_A;
   logic [DATA_W-1:0] R_Data_B;
   logic              ZF_Q;
   logic              OF_Q;
   logic              Busy;

   modport master (
      output R_Addr_A, R_Addr_B, W_Addr, Write_Reg, ALU_F, ALU_ZF, ALU_OF,
             Flag_Load, SW_Byte, Byte_Load,
      input  R_Data_A, R_Data_B, ZF_Q, OF_Q, Busy
   );

   modport slave (
      input  R_Addr_A, R_Addr_B, W_Addr, Write_Reg, ALU_F, ALU_ZF, ALU_OF,
             Flag_Load, SW_Byte, Byte_Load,
      output R_Data_A, R_Data_B, ZF_Q, OF_Q, Busy
   );
endinterface

// File: rtl/alu_reg_file_byte_word_loader.sv
// rtl/alu_reg_file_byte_word_loader.sv - assembles four switch bytes (MSB first) into one word
module byte_word_loader
   import alu_reg_file_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  sw_byte,
   input  logic        byte_load,
   output logic [31:0] word,
   output logic        word_valid,
   output logic        busy
);
   loader_state_t state;
   logic [31:0]   shift;
   logic          busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= L0;
         shift  <= '0;
         busy_q <= 1'b0;
      end else if (byte_load) begin
         shift <= {shift[23:0], sw_byte};
         case (state)
            L0: begin state <= L1; busy_q <= 1'b1; end
            L1: state <= L2;
            L2: state <= L3;
            L3: begin state <= L0; busy_q <= 1'b0; end
         endcase
      end
   end

   // The completing byte comes straight from the switches so the word is written on that edge.
   assign word       = {shift[23:0], sw_byte};
   assign word_valid = byte_load && (state == L3);
   assign busy       = busy_q;
endmodule

// File: rtl/alu_reg_file.sv
// rtl/alu_reg_file.sv - 32x32 register file with byte loader and flag latch; REG_BYPASS_EN enables write-through reads
module alu_reg_file #(
   parameter int ADDR_W = alu_reg_file_pkg::ADDR_W,
   parameter int DATA_W = alu_reg_file_pkg::DATA_W
) (
   input logic           clk,
   input logic           rst,
   alu_reg_file_if.slave bus
);
   import alu_reg_file_pkg::*;

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs [2**ADDR_W];
   logic [31:0]       word;
   logic              word_valid;
   logic              busy;
   logic              wen;
   logic [DATA_W-1:0] wdata;
   logic              zf_q;
   logic              of_q;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;

   byte_word_loader u_loader (
      .clk        (clk),
      .rst        (rst),
      .sw_byte    (bus.SW_Byte),
      .byte_load  (bus.Byte_Load),
      .word       (word),
      .word_valid (word_valid),
      .busy       (busy)
   );

   // A completing loader word takes the write port over any same-cycle ALU write-back.
   assign wen   = (word_valid || bus.Write_Reg) && (bus.W_Addr != ZERO_ADDR);
   assign wdata = word_valid ? word : bus.ALU_F;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
         zf_q <= 1'b0;
         of_q <= 1'b0;
      end else begin
         if (wen) regs[bus.W_Addr] <= wdata;
         if (bus.Flag_Load) begin
            zf_q <= bus.ALU_ZF;
            of_q <= bus.ALU_OF;
         end
      end
   end

   always_comb begin
      rdata_a = regs[bus.R_Addr_A];
      rdata_b = regs[bus.R_Addr_B];
`ifdef REG_BYPASS_EN
      if (wen && (bus.R_Addr_A == bus.W_Addr)) rdata_a = wdata;
      if (wen && (bus.R_Addr_B == bus.W_Addr)) rdata_b = wdata;
`endif
      if (bus.R_Addr_A == ZERO_ADDR) rdata_a = '0;
      if (bus.R_Addr_B == ZERO_ADDR) rdata_b = '0;
   end

   assign bus.R_Data_A = rdata_a;
   assign bus.R_Data_B = rdata_b;
   assign bus.ZF_Q     = zf_q;
   assign bus.OF_Q     = of_q;
   assign bus.Busy     = busy;
endmodule
